// File: rtl/mux5_2_1_sync.sv
// 2:1 word selector with a combinational output and a registered copy behind a
// valid/ready handshake, using a one-entry skid buffer so in_ready never depends on out_ready.
module mux5_2_1_sync #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sel,
   output logic [WIDTH-1:0] O,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] O_q,
   output logic             out_valid,
   input  logic             out_ready
);

   function automatic logic [WIDTH-1:0] sel_word(input logic s,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      return s ? b : a;
   endfunction

   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic             main_valid_q, main_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_valid_q, skid_valid_d;

   logic [WIDTH-1:0] sel_f;
   logic             accept;
   logic             main_free;

   assign O         = sel_word(Sel, A, B);
   assign sel_f     = sel_word(Sel, A, B);
   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid & !skid_valid_q;
   assign main_free = !main_valid_q | out_ready;
   assign O_q       = main_data_q;
   assign out_valid = main_valid_q;

   // Next-state: the skid entry always refills the main register before new input does.
   always_comb begin
      main_data_d  = main_data_q;
      main_valid_d = main_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      if (main_free) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_data_d  = sel_f;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_data_d  = sel_f;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_data_q  <= '0;
         main_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_data_q  <= main_data_d;
         main_valid_q <= main_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

// File: tb/tb_mux5_2_1_sync.sv
// Directed bench for mux5_2_1_sync: combinational select plus the registered skid-buffered path.
module tb_mux5_2_1_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] a, b;
   logic       sel;
   logic [4:0] o;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] o_q;
   logic       out_valid;
   logic       out_ready;

   int n_cmp = 0;
   int n_err = 0;

   mux5_2_1_sync #(.WIDTH(5)) dut (
      .clk(clk), .rst(rst), .A(a), .B(b), .Sel(sel), .O(o),
      .in_valid(in_valid), .in_ready(in_ready), .O_q(o_q),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b1; a = 5'h02; b = 5'h05;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_cmp++; if (o_q !== 5'h00) begin n_err++; $display("FAIL reset_o_q got %h exp 00", o_q); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_cmp++; if (o !== 5'h05) begin n_err++; $display("FAIL reset_o_comb got %h exp 05", o); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_truth_table();
      logic [4:0] exp_o [8] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd1, 5'd0, 5'd1};
      for (int i = 0; i < 8; i++) begin
         sel = (i >= 4);
         a   = {4'd0, i[1]};
         b   = {4'd0, i[0]};
         #100;
         n_cmp++; if (o !== exp_o[i]) begin n_err++; $display("FAIL truth_table_%0d got %h exp %h", i, o, exp_o[i]); end
      end
   endtask

   task automatic test_full_width();
      logic [4:0] av [2] = '{5'h1F, 5'h15};
      for (int i = 0; i < 2; i++) begin
         a = av[i]; b = 5'h0A;
         sel = 1'b0; #10;
         n_cmp++; if (o !== av[i]) begin n_err++; $display("FAIL full_width_sel0_%0d got %h exp %h", i, o, av[i]); end
         sel = 1'b1; #10;
         n_cmp++; if (o !== 5'h0A) begin n_err++; $display("FAIL full_width_sel1_%0d got %h exp 0a", i, o); end
         sel = 1'b0; #10;
         n_cmp++; if (o !== av[i]) begin n_err++; $display("FAIL full_width_back_%0d got %h exp %h", i, o, av[i]); end
      end
   endtask

   task automatic test_streaming();
      logic       sv [3] = '{1'b0, 1'b1, 1'b1};
      logic [4:0] avv[3] = '{5'h03, 5'h03, 5'h10};
      logic [4:0] bvv[3] = '{5'h07, 5'h07, 5'h11};
      logic [4:0] ev [3] = '{5'h03, 5'h07, 5'h11};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; sel = sv[i]; a = avv[i]; b = bvv[i];
         step();
         n_cmp++; if (o_q !== ev[i]) begin n_err++; $display("FAIL stream_o_q_%0d got %h exp %h", i, o_q, ev[i]); end
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid_%0d got %b exp 1", i, out_valid); end
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready_%0d got %b exp 1", i, in_ready); end
      end
      in_valid = 1'b0; a = 5'h1E;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid got %b exp 0", out_valid); end
      n_cmp++; if (o_q !== 5'h11) begin n_err++; $display("FAIL stream_hold_o_q got %h exp 11", o_q); end
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0; sel = 1'b0; b = 5'h1F;
      in_valid = 1'b1; a = 5'd4;
      step();
      n_cmp++; if (o_q !== 5'd4 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first got %h/%b exp 04/1", o_q, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_first got %b exp 1", in_ready); end
      a = 5'd9;
      step();
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b exp 0", in_ready); end
      n_cmp++; if (o_q !== 5'd4) begin n_err++; $display("FAIL bp_hold1 got %h exp 04", o_q); end
      a = 5'd12;
      step();
      step();
      n_cmp++; if (o_q !== 5'd4 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold2 got %h/%b exp 04/1", o_q, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_stall got %b exp 0", in_ready); end
      out_ready = 1'b1;
      step();
      n_cmp++; if (o_q !== 5'd9 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out2 got %h/%b exp 09/1", o_q, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise got %b exp 1", in_ready); end
      step();
      n_cmp++; if (o_q !== 5'd12 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out3 got %h/%b exp 0c/1", o_q, out_valid); end
      in_valid = 1'b0;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b exp 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; sel = 1'b0; in_valid = 1'b1;
      a = 5'd1; step();
      a = 5'd2; step();
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_skid_full got %b exp 0", in_ready); end
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
      n_cmp++; if (o_q !== 5'd0) begin n_err++; $display("FAIL rmid_o_q got %h exp 00", o_q); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got %b exp 1", in_ready); end
      out_ready = 1'b1; in_valid = 1'b1; a = 5'd6;
      step();
      n_cmp++; if (o_q !== 5'd6 || out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_word got %h/%b exp 06/1", o_q, out_valid); end
      in_valid = 1'b0;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_alone got %b exp 0", out_valid); end
   endtask

   task automatic test_idle();
      rst = 1'b1; step(); rst = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; b = 5'h0B;
      for (int i = 0; i < 5; i++) begin
         a = 5'(i + 16); sel = i[0];
         step();
         n_cmp++; if (out_valid !== 1'b0 || o_q !== 5'd0) begin n_err++; $display("FAIL idle_%0d got %h/%b exp 00/0", i, o_q, out_valid); end
         n_cmp++; if (o !== (i[0] ? 5'h0B : 5'(i + 16))) begin n_err++; $display("FAIL idle_o_%0d got %h", i, o); end
      end
   endtask

   initial begin
      rst = 1'b1; a = '0; b = '0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      test_reset();
      test_truth_table();
      test_full_width();
      test_streaming();
      test_back_pressure();
      test_reset_mid();
      test_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
